// File: rtl/ahb_sram_pkg.sv
// Shared AHB-Lite encodings and the controller state type for the SRAM
// slave.
package ahb_sram_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam logic HRESP_OKAY  = 1'b0;
  localparam logic HRESP_ERROR = 1'b1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD,
    S_WR,
    S_RD_STALL,
    S_ERR1,
    S_ERR2
  } state_t;

endpackage

// File: rtl/ahb_sram_ctrl.sv
// AHB-Lite slave in front of a single-port SRAM with registered read data.
// Reads are zero-wait, writes land in the data phase, and a read that
// collides with a write costs one stall.
module ahb_sram_ctrl
  import ahb_sram_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 64,
  parameter int ADDR_WIDTH = $clog2(DEPTH),
  parameter int SIZE_CODE  = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  hsel,
  input  logic [31:0]           haddr,
  input  logic [1:0]            htrans,
  input  logic                  hwrite,
  input  logic [2:0]            hsize,
  input  logic [DATA_WIDTH-1:0] hwdata,
  input  logic                  hready,
  output logic                  hreadyout,
  output logic                  hresp,
  output logic [DATA_WIDTH-1:0] hrdata,
  output logic                  sram_csen_n,
  output logic                  sram_we,
  output logic [ADDR_WIDTH-1:0] sram_addr,
  output logic [DATA_WIDTH-1:0] sram_din,
  input  logic [DATA_WIDTH-1:0] sram_dout_reg
);

  state_t                state, state_nxt;
  logic [ADDR_WIDTH-1:0] addr_q, addr_nxt;
  logic                  accept;
  logic                  req_err;
  logic [31:0]           word_idx;
  logic [ADDR_WIDTH-1:0] req_word;

  // Gated by rst so nothing can reach the SRAM pins while reset is held.
  assign accept   = !rst && hsel && hready &&
                    (htrans == HTRANS_NONSEQ || htrans == HTRANS_SEQ);
  assign word_idx = haddr >> SIZE_CODE;
  assign req_word = haddr[SIZE_CODE +: ADDR_WIDTH];
  assign req_err  = (hsize != 3'(SIZE_CODE)) ||
                    (haddr[SIZE_CODE-1:0] != '0) ||
                    (word_idx >= 32'(DEPTH));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= S_IDLE;
      addr_q <= '0;
    end else begin
      state  <= state_nxt;
      addr_q <= addr_nxt;
    end
  end

  always_comb begin
    state_nxt = S_IDLE;
    addr_nxt  = addr_q;
    if (accept) begin
      if (req_err) begin
        state_nxt = S_ERR1;
      end else if (hwrite) begin
        state_nxt = S_WR;
        addr_nxt  = req_word;
      end else if (state == S_WR) begin
        // SRAM port is busy with the write; replay the read next cycle.
        state_nxt = S_RD_STALL;
        addr_nxt  = req_word;
      end else begin
        state_nxt = S_RD;
      end
    end else begin
      case (state)
        S_RD_STALL: state_nxt = S_RD;
        S_ERR1:     state_nxt = S_ERR2;
        default:    state_nxt = S_IDLE;
      endcase
    end
  end

  always_comb begin
    hreadyout   = 1'b1;
    hresp       = HRESP_OKAY;
    hrdata      = '0;
    sram_csen_n = 1'b1;
    sram_we     = 1'b0;
    sram_addr   = '0;
    sram_din    = '0;
    case (state)
      S_RD: hrdata = sram_dout_reg;
      S_WR: begin
        sram_csen_n = 1'b0;
        sram_we     = 1'b1;
        sram_addr   = addr_q;
        sram_din    = hwdata;
      end
      S_RD_STALL: begin
        hreadyout   = 1'b0;
        sram_csen_n = 1'b0;
        sram_addr   = addr_q;
      end
      S_ERR1: begin
        hreadyout = 1'b0;
        hresp     = HRESP_ERROR;
      end
      S_ERR2: hresp = HRESP_ERROR;
      default: ;
    endcase
    // Zero-wait read: issue in the address phase unless a write owns the port.
    if (accept && !req_err && !hwrite && state != S_WR) begin
      sram_csen_n = 1'b0;
      sram_we     = 1'b0;
      sram_addr   = req_word;
    end
  end

endmodule

// File: tb/tb_ahb_sram_ctrl.sv
// Bench for ahb_sram_ctrl: pipelined AHB master, behavioural SRAM, and a
// word-array reference model checked on every completed data phase.
module tb_ahb_sram_ctrl;
  import ahb_sram_pkg::*;

  localparam int DW    = 32;
  localparam int DEPTH = 64;
  localparam int AW    = 6;

  logic          clk = 1'b0;
  logic          rst;
  logic          hsel;
  logic [31:0]   haddr;
  logic [1:0]    htrans;
  logic          hwrite;
  logic [2:0]    hsize;
  logic [DW-1:0] hwdata;
  logic          hready;
  logic          hready_low;
  logic          hreadyout;
  logic          hresp;
  logic [DW-1:0] hrdata;
  logic          sram_csen_n;
  logic          sram_we;
  logic [AW-1:0] sram_addr;
  logic [DW-1:0] sram_din;
  logic [DW-1:0] sram_dout_reg;
  logic          mem_clr;

  always #5 clk = ~clk;

  assign hready = hready_low ? 1'b0 : hreadyout;

  ahb_sram_ctrl #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .ADDR_WIDTH(AW), .SIZE_CODE(2)) dut (
    .clk(clk), .rst(rst), .hsel(hsel), .haddr(haddr), .htrans(htrans),
    .hwrite(hwrite), .hsize(hsize), .hwdata(hwdata), .hready(hready),
    .hreadyout(hreadyout), .hresp(hresp), .hrdata(hrdata),
    .sram_csen_n(sram_csen_n), .sram_we(sram_we), .sram_addr(sram_addr),
    .sram_din(sram_din), .sram_dout_reg(sram_dout_reg)
  );

  // Single-port SRAM with registered read data.
  logic [DW-1:0] mem [DEPTH];
  always @(posedge clk) begin
    if (mem_clr) begin
      for (int k = 0; k < DEPTH; k++) mem[k] <= '0;
    end else if (!sram_csen_n) begin
      if (sram_we) mem[sram_addr] <= sram_din;
      else         sram_dout_reg  <= mem[sram_addr];
    end
  end

  typedef enum int {K_IDLE, K_WR, K_RD, K_BUSY, K_NOSEL} kind_t;
  typedef struct {
    kind_t       kind;
    logic [31:0] addr;
    logic [2:0]  size;
    logic [31:0] data;
  } op_t;

  op_t         ops[$];
  logic [31:0] ref_mem [DEPTH];
  int          checks = 0;
  int          errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic op_t mk(kind_t k, logic [31:0] a, logic [31:0] d, logic [2:0] s);
    op_t o;
    o.kind = k; o.addr = a; o.data = d; o.size = s;
    return o;
  endfunction

  function automatic bit legal(op_t o);
    return (o.size == 3'd2) && (o.addr[1:0] == 2'b00) && (o.addr < 32'h100);
  endfunction

  task automatic drive_addr(input op_t o);
    hsel   = 1'b1;
    haddr  = o.addr;
    hsize  = o.size;
    hwrite = (o.kind != K_RD);
    htrans = $urandom_range(0, 1) ? HTRANS_SEQ : HTRANS_NONSEQ;
    case (o.kind)
      K_IDLE:  htrans = HTRANS_IDLE;
      K_BUSY:  htrans = HTRANS_BUSY;
      K_NOSEL: hsel   = 1'b0;
      default: ;
    endcase
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_hreadyout"}, hreadyout, 1);
    chk({tag, "_hresp"}, hresp, 0);
    chk({tag, "_hrdata"}, hrdata, 0);
    chk({tag, "_csen_n"}, sram_csen_n, 1);
    chk({tag, "_we"}, sram_we, 0);
    chk({tag, "_addr"}, sram_addr, 0);
    chk({tag, "_din"}, sram_din, 0);
  endtask

  // Pipelined master: address phase of op i overlaps data phase of op i-1.
  task automatic run_ops();
    op_t dp, cur;
    bit  dp_v, rdy, done_lwr;
    int  i, waits, exp_waits;
    i = 0; dp_v = 0; waits = 0; exp_waits = 0;
    dp = mk(K_IDLE, 0, 0, 3'd2);
    for (int cyc = 0; cyc < ops.size() * 4 + 20; cyc++) begin
      if (i >= ops.size() && !dp_v) break;
      cur = (i < ops.size()) ? ops[i] : mk(K_IDLE, 0, 0, 3'd2);
      drive_addr(cur);
      hwdata = (dp_v && dp.kind == K_WR) ? dp.data : $urandom;
      done_lwr = 0;
      @(negedge clk);
      rdy = hreadyout;
      if (dp_v) begin
        if (!rdy) begin
          waits++;
          chk("wait_hrdata", hrdata, 0);
          chk("wait_hresp", hresp, legal(dp) ? 0 : 1);
          if (!legal(dp)) chk("err1_csen_n", sram_csen_n, 1);
          if (waits > 3) begin
            chk("wait_bound", waits, exp_waits);
            dp_v = 0;
          end
        end else begin
          chk("wait_states", waits, exp_waits);
          if (legal(dp)) begin
            chk("hresp_okay", hresp, 0);
            if (dp.kind == K_RD) chk("read_data", hrdata, ref_mem[dp.addr >> 2]);
            else begin
              ref_mem[dp.addr >> 2] = dp.data;
              done_lwr = 1;
            end
          end else begin
            chk("hresp_error", hresp, 1);
          end
          dp_v = 0;
        end
      end else if (cur.kind != K_RD) begin
        chk("idle_csen_n", sram_csen_n, 1);
      end
      @(posedge clk);
      if (rdy && i < ops.size()) begin
        if (ops[i].kind == K_WR || ops[i].kind == K_RD) begin
          if (!legal(ops[i]))          exp_waits = 1;
          else if (ops[i].kind == K_RD) exp_waits = done_lwr ? 1 : 0;
          else                          exp_waits = 0;
          dp = ops[i]; dp_v = 1; waits = 0;
        end
        i++;
      end
      #1;
    end
    if (dp_v || i < ops.size()) chk("run_timeout", 0, 1);
    ops.delete();
    drive_addr(mk(K_IDLE, 0, 0, 3'd2));
  endtask

  initial begin
    op_t o;
    int  r;
    rst = 1'b1; hready_low = 1'b0; mem_clr = 1'b1;
    drive_addr(mk(K_IDLE, 0, 0, 3'd2));
    hwdata = '0;
    for (int k = 0; k < DEPTH; k++) ref_mem[k] = '0;
    repeat (2) @(posedge clk);
    #1;
    chk_reset_outputs("reset");
    mem_clr = 1'b0;
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;

    // Reset asserted in the WR data phase: write must be dropped.
    drive_addr(mk(K_WR, 32'h4, 0, 3'd2));
    @(posedge clk); #1;
    drive_addr(mk(K_IDLE, 0, 0, 3'd2));
    hwdata = 32'hDEADBEEF;
    chk("wr_phase_we", sram_we, 1);
    #2 rst = 1'b1;
    #1 chk_reset_outputs("midrst");
    @(posedge clk); #1;
    chk("midrst_edge_csen_n", sram_csen_n, 1);
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;

    // Write, idle, read; plus the word hit by the dropped write.
    ops.push_back(mk(K_WR, 32'h10, 32'hA5A5A5A5, 3'd2));
    ops.push_back(mk(K_IDLE, 0, 0, 3'd2));
    ops.push_back(mk(K_RD, 32'h10, 0, 3'd2));
    ops.push_back(mk(K_RD, 32'h4, 0, 3'd2));
    run_ops();

    // Write directly followed by read of the same word.
    ops.push_back(mk(K_WR, 32'h20, 32'h12345678, 3'd2));
    ops.push_back(mk(K_RD, 32'h20, 0, 3'd2));
    run_ops();

    // Back-to-back writes then reads.
    for (int k = 0; k < 4; k++) ops.push_back(mk(K_WR, 32'(k * 4), 32'(k + 1), 3'd2));
    for (int k = 0; k < 4; k++) ops.push_back(mk(K_RD, 32'(k * 4), 0, 3'd2));
    run_ops();

    // Error responses, then confirm the words are untouched.
    ops.push_back(mk(K_WR, 32'h0, 32'hBAD0BAD0, 3'd1));
    ops.push_back(mk(K_WR, 32'h2, 32'hBAD1BAD1, 3'd2));
    ops.push_back(mk(K_WR, 32'h100, 32'hBAD2BAD2, 3'd2));
    ops.push_back(mk(K_RD, 32'h4, 0, 3'd1));
    ops.push_back(mk(K_RD, 32'h0, 0, 3'd2));
    ops.push_back(mk(K_RD, 32'h4, 0, 3'd2));
    run_ops();

    // Non-transfers: BUSY and deselected writes.
    ops.push_back(mk(K_BUSY, 32'hC, 32'hCAFE0001, 3'd2));
    ops.push_back(mk(K_NOSEL, 32'hC, 32'hCAFE0002, 3'd2));
    ops.push_back(mk(K_IDLE, 0, 0, 3'd2));
    ops.push_back(mk(K_RD, 32'hC, 0, 3'd2));
    run_ops();

    // Valid write presented while bus hready is low.
    drive_addr(mk(K_WR, 32'h8, 0, 3'd2));
    hready_low = 1'b1;
    @(negedge clk); chk("hready_low_csen_n", sram_csen_n, 1);
    @(posedge clk); #1;
    hready_low = 1'b0;
    drive_addr(mk(K_IDLE, 0, 0, 3'd2));
    hwdata = 32'h55555555;
    @(negedge clk); chk("hready_low_dp_csen_n", sram_csen_n, 1);
    @(posedge clk); #1;
    ops.push_back(mk(K_RD, 32'h8, 0, 3'd2));
    run_ops();

    // Randomised mixed traffic over a small window to force collisions.
    for (int n = 0; n < 400; n++) begin
      r = $urandom_range(0, 11);
      o = mk(K_IDLE, {24'd0, 4'($urandom_range(0, 15)), 2'b00}, $urandom, 3'd2);
      if (r >= 1 && r <= 4)      o.kind = K_WR;
      else if (r >= 5 && r <= 8) o.kind = K_RD;
      else if (r == 9) begin
        o.kind = $urandom_range(0, 1) ? K_WR : K_RD;
        case ($urandom_range(0, 2))
          0: o.size = 3'($urandom_range(0, 1));
          1: o.addr = o.addr | 32'($urandom_range(1, 3));
          default: o.addr = 32'h100 + 32'($urandom_range(0, 63) * 4);
        endcase
      end else if (r == 10) o.kind = K_BUSY;
      else if (r == 11)     o.kind = K_NOSEL;
      ops.push_back(o);
    end
    run_ops();

    // Final sweep of every word against the reference.
    for (int k = 0; k < DEPTH; k++) ops.push_back(mk(K_RD, 32'(k * 4), 0, 3'd2));
    run_ops();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
